cla_divider: RTL and testbench



---
 rtl/cla_arith_pkg.sv | 19 +
 rtl/cla_subtractor.sv | 70 +++++++
 rtl/cla_divider.sv | 116 +++++++++++
 tb/tb_cla_divider.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_arith_pkg.sv
// Shared definitions for the carry-lookahead arithmetic blocks.
//   div_state_t : divider FSM encoding (IDLE=0, CALC=1, DONE=2)
//   CLA_GRP     : bits per carry-lookahead group
//   cnt_width() : width of a counter able to hold 0..w (ceil log2 of w+1)
package cla_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int CLA_GRP = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Carry-lookahead subtractor: diff = a - b, computed as a + ~b + 1.
// Bits are split into CLA_GRP-wide lookahead groups; each group resolves its
// internal carries from per-bit generate/propagate terms, and group carries
// chain from one group to the next. The top group may be partial.
//   a, b   : N-bit unsigned operands
//   diff   : N-bit difference (mod 2^N)
//   borrow : 1 when a < b (inverted carry out)
module cla_subtractor
  import cla_arith_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NG = (N + CLA_GRP - 1) / CLA_GRP;
  localparam int NP = NG * CLA_GRP;

  logic [N-1:0]  w_g, w_p;
  logic [NP-1:0] w_gx, w_px;

  assign w_g = a & ~b;
  assign w_p = a ^ ~b;

  // Pad the partial top group with pure-propagate bits so its group
  // carry-out equals the carry out of bit N-1.
  always_comb begin
    w_gx          = '0;
    w_px          = '1;
    w_gx[N-1:0]   = w_g;
    w_px[N-1:0]   = w_p;
  end

  always_comb begin : cla_net
    logic [NG:0]   gc;
    logic [NP-1:0] c;
    logic          t, u, gg, gp;
    gc    = '0;
    c     = '0;
    gc[0] = 1'b1;  // +1 of the two's complement
    for (int k = 0; k < NG; k++) begin
      // Carry into bit j of the group: group carry-in propagated through
      // bits 0..j-1, OR any lower bit m that generates and propagates up.
      for (int j = 0; j < CLA_GRP; j++) begin
        t = gc[k];
        for (int m = 0; m < j; m++) t = t & w_px[k*CLA_GRP+m];
        for (int m = 0; m < j; m++) begin
          u = w_gx[k*CLA_GRP+m];
          for (int q = m + 1; q < j; q++) u = u & w_px[k*CLA_GRP+q];
          t = t | u;
        end
        c[k*CLA_GRP+j] = t;
      end
      gp = &w_px[k*CLA_GRP +: CLA_GRP];
      gg = 1'b0;
      for (int m = 0; m < CLA_GRP; m++) begin
        u = w_gx[k*CLA_GRP+m];
        for (int q = m + 1; q < CLA_GRP; q++) u = u & w_px[k*CLA_GRP+q];
        gg = gg | u;
      end
      gc[k+1] = gg | (gp & gc[k]);
    end
    diff   = w_p ^ c[N-1:0];
    borrow = ~gc[NG];
  end

endmodule

// File: rtl/cla_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, using
// the lookahead subtractor for the trial subtraction.
//   clk, rst            : clock, async active-high reset
//   start               : request; accepted in IDLE or DONE
//   dividend, divisor   : operands, sampled with an accepted start
//   busy                : high while iterating (CALC)
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : divisor was 0 (quotient all ones, remainder dividend)
module cla_divider
  import cla_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_t       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;   // partial remainder; always < divisor so WIDTH bits hold it
  logic [WIDTH-1:0] r_q;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_quot, r_remd;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift, w_diff;
  logic [WIDTH-1:0] w_rem_nxt, w_q_nxt;
  logic             w_borrow, w_accept, w_last, w_dvsr_zero;
  logic             w_diff_top_unused;

  // R' = {R, next dividend bit}, one bit wider than R
  assign w_shift = {r_rem, r_q[WIDTH-1]};

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a      (w_shift),
    .b      ({1'b0, r_dvsr}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  // When there is no borrow the difference is below the divisor, so its
  // top bit is always 0 and the low WIDTH bits carry the whole value.
  assign w_diff_top_unused = w_diff[WIDTH];
  assign w_rem_nxt   = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_q_nxt     = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_last      = (r_cnt == LAST);
  assign w_dvsr_zero = (divisor == '0);
  assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_state_nxt = w_dvsr_zero ? DONE : CALC;
        else       w_state_nxt = IDLE;
      end
      CALC:    if (w_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_dvsr <= '0;
      r_quot <= '0;
      r_remd <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_dvsr <= divisor;
      r_q    <= dividend;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_dbz  <= w_dvsr_zero;
      // Divide by zero resolves immediately; no iterations are run.
      if (w_dvsr_zero) begin
        r_quot <= '1;
        r_remd <= dividend;
      end
    end else if (r_state == CALC) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_quot <= w_q_nxt;
        r_remd <= w_rem_nxt;
      end
    end
  end

  assign busy        = (r_state == CALC);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_cla_divider.sv
module tb_cla_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, done, dbz;

  logic [8:0]   sa, sb, sd;
  logic         sbw;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (dbz)
  );

  cla_subtractor #(.N(9)) u_sub (
    .a      (sa),
    .b      (sb),
    .diff   (sd),
    .borrow (sbw)
  );

  // Reference: plain integer division, divide-by-zero convention.
  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Present a start for one edge, then scramble operand inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
  endtask

  // Called 1 time unit after the start edge; lat = edges after it until done.
  task automatic wait_done(output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int n = 0; n <= 3 * W; n++) begin
      if (done) begin lat = n; break; end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
               busy, done, dbz, quotient, remainder);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    issue(8'd100, 8'd7);
    wait_done(lat, bc);
    checks++; if (quotient !== 8'd14) begin failures++; $display("FAIL basic_q got %0d want 14", quotient); end
    checks++; if (remainder !== 8'd2) begin failures++; $display("FAIL basic_r got %0d want 2", remainder); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL basic_dbz got %b want 0", dbz); end
    checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width got %b want 0", done); end
    checks++; if (quotient !== 8'd14 || remainder !== 8'd2) begin
      failures++; $display("FAIL basic_hold got %0d/%0d want 14/2", quotient, remainder);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] ea [5] = '{8'd255, 8'd255, 8'd5, 8'd0, 8'd128};
    logic [W-1:0] eb [5] = '{8'd1,   8'd255, 8'd9, 8'd3, 8'd2};
    logic [W-1:0] eq [5] = '{8'd255, 8'd1,   8'd0, 8'd0, 8'd64};
    logic [W-1:0] er [5] = '{8'd0,   8'd0,   8'd5, 8'd0, 8'd0};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      issue(ea[i], eb[i]);
      wait_done(lat, bc);
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || dbz !== 1'b0 || lat !== 8) begin
        failures++;
        $display("FAIL edge_%0d_%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=0 lat=8",
                 ea[i], eb[i], quotient, remainder, dbz, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div0();
    int lat, bc;
    issue(8'd37, 8'd0);
    wait_done(lat, bc);
    checks++; if (lat !== 0) begin failures++; $display("FAIL div0_latency got %0d want 0", lat); end
    checks++; if (busy !== 1'b0 || bc !== 0) begin failures++; $display("FAIL div0_busy got %b/%0d want 0/0", busy, bc); end
    checks++; if (quotient !== 8'hFF) begin failures++; $display("FAIL div0_q got %0h want ff", quotient); end
    checks++; if (remainder !== 8'd37) begin failures++; $display("FAIL div0_r got %0d want 37", remainder); end
    checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL div0_flag got %b want 1", dbz); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || dbz !== 1'b1) begin
      failures++; $display("FAIL div0_after got done=%b busy=%b dbz=%b want 0 0 1", done, busy, dbz);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(8'd50, 8'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got %b want 1", busy); end
    wait_done(lat, bc);
    checks++; if (lat !== 5) begin failures++; $display("FAIL ignore_latency got %0d want 5", lat); end
    checks++; if (quotient !== 8'd16 || remainder !== 8'd2) begin
      failures++; $display("FAIL ignore_result got %0d/%0d want 16/2", quotient, remainder);
    end
    // Still inside the DONE cycle: start again immediately.
    start = 1'b1; dividend = 8'd200; divisor = 8'd10;
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    wait_done(lat, bc);
    checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_latency got %0d want 8", lat); end
    checks++; if (quotient !== 8'd20 || remainder !== 8'd0 || dbz !== 1'b0) begin
      failures++; $display("FAIL b2b_result got %0d/%0d dbz=%b want 20/0 dbz=0", quotient, remainder, dbz);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc, seen;
    issue(8'd123, 8'd4);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== '0) begin
      failures++;
      $display("FAIL areset_outputs got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
               busy, done, dbz, quotient, remainder);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    seen = 0;
    repeat (3 * W) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL areset_no_done got %0d active cycles want 0", seen); end
    issue(8'd77, 8'd8);
    wait_done(lat, bc);
    checks++; if (quotient !== 8'd9 || remainder !== 8'd5 || lat !== 8) begin
      failures++; $display("FAIL areset_next got %0d/%0d lat=%0d want 9/5 lat=8", quotient, remainder, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int lat, bc;
    for (int i = 0; i < 2000; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      issue(a, b);
      wait_done(lat, bc);
      checks++;
      if (quotient !== ref_q(a, b) || remainder !== ref_r(a, b) || dbz !== (b == 0) ||
          lat !== ((b == 0) ? 0 : 8)) begin
        failures++;
        $display("FAIL rand_%0d_%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b",
                 a, b, quotient, remainder, dbz, lat, ref_q(a, b), ref_r(a, b), b == 0);
      end
      if (b != 0) begin
        checks++;
        if ((int'(quotient) * int'(b) + int'(remainder)) != int'(a) || remainder >= b) begin
          failures++;
          $display("FAIL rand_identity_%0d_%0d got q=%0d r=%0d want q*d+r=n and r<d",
                   a, b, quotient, remainder);
        end
      end
    end
  endtask

  task automatic test_subtractor();
    int bad, fa, fb;
    logic [8:0] ed;
    logic       eb;
    bad = 0; fa = 0; fb = 0;
    for (int i = 0; i < 512; i++) begin
      for (int j = 0; j < 512; j++) begin
        sa = 9'(i); sb = 9'(j);
        #1;
        ed = 9'(i - j);
        eb = (i < j);
        if (sd !== ed || sbw !== eb) begin
          if (bad == 0) begin fa = i; fb = j; end
          bad++;
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      sa = 9'(fa); sb = 9'(fb); #1;
      $display("FAIL sub_exhaustive got %0d bad vectors (first %0d-%0d: diff=%0d borrow=%b) want 0 (diff=%0d borrow=%b)",
               bad, fa, fb, sd, sbw, 9'(fa - fb), fa < fb);
    end
  endtask

  initial begin
    sa = '0; sb = '0;
    test_reset();
    test_basic();
    test_edges();
    test_div0();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_subtractor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
